pipelined_adder: RTL

//   Parametrised, pipelined carry-chained adder; next generation of the half/full adder primitives.

---
 rtl/pipelined_adder_pkg.sv | 34 +++
 rtl/pipelined_adder_chunk.sv | 22 ++
 rtl/pipelined_adder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared helpers and stage-control types for pipelined_adder.
// Optional feature macro: PIPELINED_ADDER_OVF_EN (adds operand sign bits to the stage control word).
package pipelined_adder_pkg;

    // Width of one pipeline chunk. A degenerate configuration still yields a
    // legal width so that only the configuration error is reported.
    function automatic int chunk_width(input int width, input int stages);
        if (stages < 1) begin
            return 1;
        end
        if (width / stages < 1) begin
            return 1;
        end
        return width / stages;
    endfunction

    // True when WIDTH splits into STAGES equal, non-empty chunks.
    function automatic bit config_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Per-stage control word. The partial sum and the pending operand chunks
    // change width from stage to stage, so the top level declares them next
    // to this word inside its stage generate loop.
    typedef struct packed {
        logic valid;
        logic carry;
`ifdef PIPELINED_ADDER_OVF_EN
        logic sign_a;
        logic sign_b;
`endif
    } stage_ctrl_t;

endpackage

// File: rtl/pipelined_adder_chunk.sv
// adder_chunk: combinational CHUNK-bit add with carry in and carry out.
// One copy sits in front of every pipeline stage register of pipelined_adder.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total;

    // One extra bit on the add holds the carry that moves on to the next chunk.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum   = total[CHUNK-1:0];
        cout  = total[CHUNK];
    end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES chunks, one chunk per
// pipeline stage, with the carry registered between stages and a valid/ready
// stream on both sides. All stages advance together; a stalled output freezes
// the whole pipe.
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds the signed-overflow
// output ovf and the operand sign bits that travel down the pipe with it.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = (STAGES < 1) ? 0 : STAGES - 1;

    if (!config_ok(WIDTH, STAGES)) begin : g_bad_config
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), with 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    logic              adv;
    logic [STAGES-1:0] valid_vec;

    // Stage k adds chunk k. src_a/src_b are the operand bits not yet consumed
    // when the transaction enters stage k; the low chunk is added here and the
    // rest is registered for the following stage. sum_q holds every chunk
    // finished so far, so the last stage carries the complete sum.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W  = WIDTH - k * CHUNK;
        localparam int DONE_W = (k + 1) * CHUNK;

        logic [SRC_W-1:0]  src_a;
        logic [SRC_W-1:0]  src_b;
        logic              carry_in;
        logic              valid_in;
`ifdef PIPELINED_ADDER_OVF_EN
        logic              sign_a_in;
        logic              sign_b_in;
`endif
        logic [CHUNK-1:0]  chunk_sum;
        logic              chunk_cout;
        logic [DONE_W-1:0] sum_d;
        logic [DONE_W-1:0] sum_q;
        stage_ctrl_t       ctrl_q;

        if (k == 0) begin : g_head
            assign src_a    = a;
            assign src_b    = b;
            assign carry_in = cin;
            assign valid_in = in_valid;
            assign sum_d    = chunk_sum;
`ifdef PIPELINED_ADDER_OVF_EN
            assign sign_a_in = a[WIDTH-1];
            assign sign_b_in = b[WIDTH-1];
`endif
        end else begin : g_body
            assign src_a    = g_stage[k-1].g_keep.pend_a_q;
            assign src_b    = g_stage[k-1].g_keep.pend_b_q;
            assign carry_in = g_stage[k-1].ctrl_q.carry;
            assign valid_in = g_stage[k-1].ctrl_q.valid;
            assign sum_d    = {chunk_sum, g_stage[k-1].sum_q};
`ifdef PIPELINED_ADDER_OVF_EN
            assign sign_a_in = g_stage[k-1].ctrl_q.sign_a;
            assign sign_b_in = g_stage[k-1].ctrl_q.sign_b;
`endif
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (src_a[CHUNK-1:0]),
            .b    (src_b[CHUNK-1:0]),
            .cin  (carry_in),
            .sum  (chunk_sum),
            .cout (chunk_cout)
        );

        // Control word and finished sum bits move one stage on every advance and clear on reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl_q <= '0;
                sum_q  <= '0;
            end else if (adv) begin
                ctrl_q.valid  <= valid_in;
                ctrl_q.carry  <= chunk_cout;
`ifdef PIPELINED_ADDER_OVF_EN
                ctrl_q.sign_a <= sign_a_in;
                ctrl_q.sign_b <= sign_b_in;
`endif
                sum_q         <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_keep
            logic [SRC_W-CHUNK-1:0] pend_a_q;
            logic [SRC_W-CHUNK-1:0] pend_b_q;

            // Operand chunks still waiting to be added follow the transaction to the next stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_a_q <= '0;
                    pend_b_q <= '0;
                end else if (adv) begin
                    pend_a_q <= src_a[SRC_W-1:CHUNK];
                    pend_b_q <= src_b[SRC_W-1:CHUNK];
                end
            end
        end

        assign valid_vec[k] = ctrl_q.valid;
    end

    // The whole pipe moves unless the output holds a result nobody is taking.
    assign out_valid = g_stage[LAST].ctrl_q.valid;
    assign cout      = g_stage[LAST].ctrl_q.carry;
    assign sum       = g_stage[LAST].sum_q;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign busy      = |valid_vec;

`ifdef PIPELINED_ADDER_OVF_EN
    // Signed overflow: equal operand signs but a result sign that differs.
    assign ovf = out_valid
               && (g_stage[LAST].ctrl_q.sign_a == g_stage[LAST].ctrl_q.sign_b)
               && (sum[WIDTH-1] != g_stage[LAST].ctrl_q.sign_a);
`endif

endmodule
